// File: rtl/bs_byte_packer.sv
// bs_byte_packer: buffers the zlib stage's 32-bit word stream in a FIFO and
// re-emits it LSB-byte-first over a valid/ready byte interface. It also keeps a
// running CRC-32 (reflected poly 0xEDB88320) and a count of accepted bytes,
// which feed the IDAT chunk's length and CRC fields.
module bs_byte_packer #(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4,
    parameter int CNT_WD     = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic              val_i,
    input  logic [31:0]       dat_i,
    input  logic              done_i,
    output logic              val_o,
    output logic [7:0]        dat_o,
    input  logic              rdy_i,
    output logic [31:0]       crc_o,
    output logic [CNT_WD-1:0] cnt_o,
    output logic              ovf_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    // One byte of reflected CRC-32, data bit 0 first.
    function automatic logic [31:0] crc8_step(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    state_e              state_q, state_d;
    logic [FIFO_AW:0]    wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]    rd_ptr_q, rd_ptr_d;
    logic [31:0]         fifo_mem [FIFO_DEPTH];
    logic [31:0]         hold_q, hold_d;
    logic [1:0]          idx_q, idx_d;
    logic                hval_q, hval_d;
    logic [31:0]         crc_q, crc_d;
    logic [CNT_WD-1:0]   cnt_q, cnt_d;
    logic                ovf_q, ovf_d;

    logic fifo_empty;
    logic fifo_full;
    logic accept;
    logic last_byte;
    logic fifo_rd;
    logic wr_req;
    logic fifo_wr;

    // Handshake and FIFO status; the pointers carry one extra wrap bit.
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                     (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
        accept     = hval_q & rdy_i;
        last_byte  = (idx_q == 2'd3);
        // The holder refills when empty or in the same cycle its last byte
        // leaves, so consecutive words stream without a bubble.
        fifo_rd    = !fifo_empty && (!hval_q || (accept && last_byte));
        wr_req     = val_i && (state_q == ST_RUN) && !start_i;
        // A full FIFO still takes a word when a read frees a slot that cycle.
        fifo_wr    = wr_req && (!fifo_full || fifo_rd);
    end

    // Next-state for pointers, byte holder, CRC, byte counter and overflow flag.
    always_comb begin
        // NOTE: every variable gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        hold_d   = hold_q;
        idx_d    = idx_q;
        hval_d   = hval_q;
        crc_d    = crc_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;

        if (fifo_wr) wr_ptr_d = wr_ptr_q + {{FIFO_AW{1'b0}}, 1'b1};
        if (fifo_rd) rd_ptr_d = rd_ptr_q + {{FIFO_AW{1'b0}}, 1'b1};

        if (fifo_rd) begin
            hold_d = fifo_mem[rd_ptr_q[FIFO_AW-1:0]];
            idx_d  = 2'd0;
            hval_d = 1'b1;
        end else if (accept) begin
            if (last_byte) hval_d = 1'b0;
            else           idx_d  = idx_q + 2'd1;
        end

        if (accept) begin
            crc_d = crc8_step(crc_q, dat_o);
            cnt_d = cnt_q + {{(CNT_WD-1){1'b0}}, 1'b1};
        end

        if (wr_req && fifo_full && !fifo_rd) ovf_d = 1'b1;

        // A new stream wipes everything, whatever was in flight.
        if (start_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            hold_d   = '0;
            idx_d    = 2'd0;
            hval_d   = 1'b0;
            crc_d    = CRC_INIT;
            cnt_d    = '0;
            ovf_d    = 1'b0;
        end
    end

    // Stream FSM next state; start_i overrides from any state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_IDLE;
            ST_RUN:   if (done_i) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty && !hval_q) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (start_i) state_d = ST_RUN;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge values; blocking ones would make results order-dependent.
        if (!rstn) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            hold_q   <= '0;
            idx_q    <= 2'd0;
            hval_q   <= 1'b0;
            crc_q    <= CRC_INIT;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            hold_q   <= hold_d;
            idx_q    <= idx_d;
            hval_q   <= hval_d;
            crc_q    <= crc_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; emptiness comes from the
        // pointers alone, and leaving it out keeps it mappable to RAM.
        if (fifo_wr) fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= dat_i;
    end

    // Outputs straight from registered state.
    always_comb begin
        val_o  = hval_q;
        dat_o  = hold_q[{idx_q, 3'b000} +: 8];
        crc_o  = ~crc_q;
        cnt_o  = cnt_q;
        ovf_o  = ovf_q;
        done_o = (state_q == ST_DONE);
    end

endmodule
